// File: rtl/bcd_scan_display.sv
// bcd_scan_display: time-multiplexed BCD -> 7-segment driver with dead-time
// ghost suppression, leading-zero blanking and frame-boundary (tear-free) commit.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   load            1-cycle strobe, captures bcd_in/dp_in into the shadow register
//   bcd_in, dp_in   packed BCD nibbles (digit 0 = LSD) and per-digit decimal points
//   blank           forces all segments/enables off while the scan keeps running
//   seg, dp         registered segment {g..a} and decimal-point pins
//   digit_en        registered one-hot digit enables
//   select          binary index of the digit being scanned
//   err             high while any active nibble is > 9
//   frame_done      1-cycle pulse after the last digit's slot ends
module bcd_scan_display #(
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned CLK_DIV     = 50000,
   parameter int unsigned BLANK_CYC   = 4,
   parameter int unsigned SEG_ACT_LOW = 0,
   parameter int unsigned SEL_ACT_LOW = 0,
   parameter int unsigned LZ_BLANK    = 1,
   localparam int unsigned SW         = $clog2(DIGITS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                blank,
   output logic [6:0]          seg,
   output logic                dp,
   output logic [DIGITS-1:0]   digit_en,
   output logic [SW-1:0]       select,
   output logic                err,
   output logic                frame_done
);

   localparam int unsigned     PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [SW-1:0]   IDX_LAST   = SW'(DIGITS - 1);
   localparam logic [6:0]      SEG_OFF    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic            DP_OFF     = (SEG_ACT_LOW != 0);
   localparam logic [DIGITS-1:0] EN_OFF   = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [PW-1:0]              r_presc;
   logic [SW-1:0]              r_idx;
   logic [DIGITS-1:0][3:0]     r_shadow;
   logic [DIGITS-1:0][3:0]     r_active;
   logic [DIGITS-1:0]          r_shadow_dp;
   logic [DIGITS-1:0]          r_active_dp;
   logic                       r_pending;
   logic                       r_err;
   logic                       r_frame_done;
   logic [6:0]                 r_seg;
   logic                       r_dp;
   logic [DIGITS-1:0]          r_digit_en;

   logic                       w_slot_end;
   logic                       w_commit;
   logic                       w_dead;
   logic [DIGITS-1:0][3:0]     w_new_active;
   logic [DIGITS-1:0]          w_new_dp;
   logic                       w_new_err;
   logic                       w_run;
   logic [DIGITS-1:0]          w_lz;
   logic [6:0]                 w_seg_log;
   logic                       w_dp_log;
   logic [DIGITS-1:0]          w_en_log;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h79;
      endcase
   endfunction

   assign w_slot_end = (r_presc == PRESC_LAST);
   assign w_commit   = w_slot_end && (r_idx == IDX_LAST);

   // A load coincident with the commit edge bypasses the shadow.
   assign w_new_active = load ? bcd_in : r_shadow;
   assign w_new_dp     = load ? dp_in  : r_shadow_dp;

   always_comb begin
      w_new_err = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (w_new_active[k] > 4'd9) w_new_err = 1'b1;
      end
   end

   // Leading-zero blanking: walk from the MSD down, stop at the first non-zero nibble or dp.
   always_comb begin
      w_run = (LZ_BLANK != 0);
      w_lz  = '0;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         w_run = w_run && (r_active[k] == 4'd0) && !r_active_dp[k];
         if (k != 0) w_lz[k] = w_run;
      end
   end

   generate
      if (BLANK_CYC == 0) begin : g_no_dead
         assign w_dead = 1'b0;
      end else begin : g_dead
         assign w_dead = (r_presc < PW'(BLANK_CYC));
      end
   endgenerate

   // Logical (active-high) output values for the current prescaler/index.
   always_comb begin
      w_seg_log = 7'h00;
      w_dp_log  = 1'b0;
      w_en_log  = '0;
      if (!w_dead && !blank) begin
         w_en_log = DIGITS'(1) << r_idx;
         if (!w_lz[r_idx]) begin
            w_seg_log = seg_decode(r_active[r_idx]);
            w_dp_log  = r_active_dp[r_idx];
         end
      end
   end

   // Prescaler and scan index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_presc      <= w_slot_end ? '0 : r_presc + PW'(1);
         if (w_slot_end) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + SW'(1);
         r_frame_done <= w_commit;
      end
   end

   // Shadow capture and frame-boundary commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         r_active    <= '0;
         r_active_dp <= '0;
         r_pending   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (load) begin
            r_shadow    <= bcd_in;
            r_shadow_dp <= dp_in;
         end
         if (w_commit) begin
            r_pending <= 1'b0;
            if (load || r_pending) begin
               r_active    <= w_new_active;
               r_active_dp <= w_new_dp;
               r_err       <= w_new_err;
            end
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   // Output pins, polarity applied last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg      <= SEG_OFF;
         r_dp       <= DP_OFF;
         r_digit_en <= EN_OFF;
      end else begin
         r_seg      <= w_seg_log ^ SEG_OFF;
         r_dp       <= w_dp_log ^ DP_OFF;
         r_digit_en <= w_en_log ^ EN_OFF;
      end
   end

   assign seg        = r_seg;
   assign dp         = r_dp;
   assign digit_en   = r_digit_en;
   assign select     = r_idx;
   assign err        = r_err;
   assign frame_done = r_frame_done;

endmodule
